// File: rtl/tx_sched_pkg.sv
// tx_word_scheduler shared types and constants.
// Word/counter widths, FSM state enum and K28.5 comma codes.
package tx_sched_pkg;

    localparam int WORD_W = 10;
    localparam int CNT_W  = 4;

    localparam logic [WORD_W-1:0] K28_5_RDN = 10'h0FA;

    // RD+ form of a K28.5 comma is the bitwise complement of RD-
    function automatic logic [WORD_W-1:0] rd_plus(input logic [WORD_W-1:0] rdn);
        return ~rdn;
    endfunction

    localparam logic [WORD_W-1:0] K28_5_RDP = ~K28_5_RDN;
    localparam logic [CNT_W-1:0]  FIRST_BIT = CNT_W'(9);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_ALIGN = 2'd1,
        S_DATA  = 2'd2
    } state_t;

endpackage

// File: rtl/tx_word_fifo.sv
// Two-entry word FIFO between the encoder handshake and the word loader.
// Push is ignored when full, pop is ignored when empty.
module tx_word_fifo
    import tx_sched_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];

    // Storage, pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/tx_word_scheduler.sv
// SerDes TX word scheduler: comma preamble, idle insertion, one word per 10 bits.
// Optional macro TX_SCHED_STATS_EN adds the IdleCount output.
module tx_word_scheduler
    import tx_sched_pkg::*;
#(
    parameter int                ALIGN_WORDS = 4,
    parameter logic [WORD_W-1:0] COMMA_RDN   = K28_5_RDN
) (
    input  logic              BitCLK,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [WORD_W-1:0] TxDataIn,
    input  logic              TxValid,
    output logic              TxReady,
    output logic [WORD_W-1:0] TxParallel_10,
    output logic [CNT_W-1:0]  bit_count,
    output logic              Load,
    output logic              IdleInserted
`ifdef TX_SCHED_STATS_EN
    ,
    output logic [15:0]       IdleCount
`endif
);

    localparam int AC_W = (ALIGN_WORDS < 2) ? 1 : $clog2(ALIGN_WORDS + 1);
    localparam logic [AC_W-1:0] ALIGN_LAST = AC_W'(ALIGN_WORDS);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  bc_q, bc_d;
    logic              load_q, load_d;
    logic              idle_q, idle_d;
    logic              rd_q, rd_d;
    logic [AC_W-1:0]   align_q, align_d;

    logic              boundary;
    logic              align_done;
    logic [WORD_W-1:0] comma_w;
    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    assign TxReady       = (state_q != S_OFF) && !fifo_full;
    assign fifo_push     = TxValid && TxReady;
    assign boundary      = (state_q == S_OFF) ? Enable : (bc_q == '0);
    assign align_done    = (align_q >= ALIGN_LAST);
    assign comma_w       = rd_q ? rd_plus(COMMA_RDN) : COMMA_RDN;
    assign TxParallel_10 = word_q;
    assign bit_count     = bc_q;
    assign Load          = load_q;
    assign IdleInserted  = idle_q;

    tx_word_fifo #(.W(WORD_W)) u_fifo (
        .clk_i   (BitCLK),
        .rst_i   (Reset),
        .push_i  (fifo_push),
        .din_i   (TxDataIn),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State register
    always_ff @(posedge BitCLK or posedge Reset) begin
        if (Reset) state_q <= S_OFF;
        else       state_q <= state_d;
    end

    // Next state: transitions only happen at word boundaries
    always_comb begin
        state_d = state_q;
        if (boundary) begin
            unique case (state_q)
                S_OFF:   state_d = S_ALIGN;
                S_ALIGN: state_d = !Enable   ? S_OFF  :
                                   align_done ? S_DATA : S_ALIGN;
                S_DATA:  state_d = Enable ? S_DATA : S_OFF;
                default: state_d = S_OFF;
            endcase
        end
    end

    // Word loading, bit countdown, disparity toggle and FIFO pop
    always_comb begin
        word_d   = word_q;
        bc_d     = bc_q;
        load_d   = 1'b0;
        idle_d   = 1'b0;
        rd_d     = rd_q;
        align_d  = align_q;
        fifo_pop = 1'b0;
        if (!boundary) begin
            if (state_q != S_OFF) bc_d = bc_q - CNT_W'(1);
        end else begin
            unique case (state_d)
                S_OFF: begin
                    word_d = '0;
                    bc_d   = '0;
                end
                S_ALIGN: begin
                    load_d = 1'b1;
                    idle_d = 1'b1;
                    bc_d   = FIRST_BIT;
                    if (state_q == S_OFF) begin
                        word_d  = COMMA_RDN;
                        rd_d    = 1'b1;
                        align_d = AC_W'(1);
                    end else begin
                        word_d  = comma_w;
                        rd_d    = ~rd_q;
                        align_d = align_q + AC_W'(1);
                    end
                end
                S_DATA: begin
                    load_d = 1'b1;
                    bc_d   = FIRST_BIT;
                    if (!fifo_empty) begin
                        word_d   = fifo_head;
                        fifo_pop = 1'b1;
                    end else begin
                        word_d = comma_w;
                        rd_d   = ~rd_q;
                        idle_d = 1'b1;
                    end
                end
                default: begin
                    word_d = '0;
                    bc_d   = '0;
                end
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge BitCLK or posedge Reset) begin
        if (Reset) begin
            word_q  <= '0;
            bc_q    <= '0;
            load_q  <= 1'b0;
            idle_q  <= 1'b0;
            rd_q    <= 1'b0;
            align_q <= '0;
        end else begin
            word_q  <= word_d;
            bc_q    <= bc_d;
            load_q  <= load_d;
            idle_q  <= idle_d;
            rd_q    <= rd_d;
            align_q <= align_d;
        end
    end

`ifdef TX_SCHED_STATS_EN
    logic        idle_cnt_inc;
    logic [15:0] idle_cnt_q;

    assign idle_cnt_inc = boundary && (state_d == S_DATA) && fifo_empty;
    assign IdleCount    = idle_cnt_q;

    // Saturating count of idle commas inserted while carrying data
    always_ff @(posedge BitCLK or posedge Reset) begin
        if (Reset) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_inc && (idle_cnt_q != 16'hFFFF)) begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: doc/tx_word_scheduler.md
# tx_word_scheduler

Word-level scheduler for the SerDes transmit path. It sits between the 8b/10b encoder and the PISO. It buffers encoded 10-bit words through a valid/ready handshake and presents one word to the PISO every 10 BitCLK cycles, with a load strobe. After enable it sends a comma alignment preamble, and it inserts idle commas with alternating disparity whenever the encoder has no data.

## Interface
- ALIGN_WORDS, 4: commas sent after enable before data is accepted for load; must be ≥1.
- COMMA_RDN, 10'h0FA: K28.5 RD− code; the RD+ code is its bitwise complement, 10'h305.
- BitCLK  in  1  bit clock, shared with the PISO; all logic on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  level; starts and stops serialization.
- TxDataIn  in  10  encoded word from the encoder.
- TxValid  in  1  TxDataIn is valid.
- TxReady  out  1  scheduler can accept a word; a transfer occurs when TxValid && TxReady at a rising edge.
- TxParallel_10  out  10  word presented to the PISO; held stable for the whole word.
- bit_count  out  4  PISO bit index: 9 down to 0.
- Load  out  1  one-cycle pulse while a freshly loaded word is presented (bit_count==9).
- IdleInserted  out  1  one-cycle pulse, coincident with Load, when the loaded word is an idle comma.

## Operation
- States: S_OFF, S_ALIGN, S_DATA.
- Word boundary: any edge in S_ALIGN or S_DATA where bit_count==0 before the edge, or the edge leaving S_OFF.
- S_OFF:
  - TxParallel_10=0, bit_count=0, Load=0, TxReady=0.
  - FIFO contents are retained.
  - On the first edge with Enable=1: go to S_ALIGN, load a comma, set bit_count=9, Load=1.
- Non-boundary edges in S_ALIGN/S_DATA: bit_count decrements by 1; TxParallel_10 holds.
- S_ALIGN:
  - Each boundary loads a comma and pulses IdleInserted.
  - Once ALIGN_WORDS commas have been loaded, the next boundary enters S_DATA and applies the S_DATA load rule.
- S_DATA, at each boundary:
  - FIFO non-empty (state before the edge): pop the head into TxParallel_10, IdleInserted=0.
  - FIFO empty: load a comma, IdleInserted=1.
- Comma disparity:
  - Commas alternate RD− and RD+ across consecutive comma loads, starting at RD−.
  - The disparity toggle is reset to RD− on Reset and on entry to S_ALIGN.
- FIFO: 2 entries, first in first out.
  - TxReady = !full in S_ALIGN and S_DATA; 0 in S_OFF.
  - Push and pop in the same edge are allowed when the FIFO is non-empty.
  - A word pushed at a boundary edge is not eligible for that boundary's pop.
- Enable deasserted mid-word: the current word completes. At the next boundary go to S_OFF, with no Load and with outputs at S_OFF values.
- Enable reasserted before that boundary: operation continues uninterrupted.
- Reset (any time, asynchronous):
  - State S_OFF, FIFO emptied, comma disparity RD−.
  - TxParallel_10=0, bit_count=0, Load=0, TxReady=0, IdleInserted=0.

## Timing
- Word period: exactly 10 BitCLK cycles; Load is high 1 cycle in 10 while active.
- Enable to first Load: 1 edge.
- Minimum accept-to-load latency: the next word boundary strictly after the accepting edge (1–10 cycles).
- TxParallel_10 changes only at boundary edges; it is stable whenever bit_count≠9 or Load=0.
- Preamble length: ALIGN_WORDS×10 cycles, independent of FIFO state.

## Configuration
- TX_SCHED_STATS_EN defined: adds output IdleCount [15:0].
  - Increments on every IdleInserted pulse in S_DATA only; alignment commas are not counted.
  - Saturates at 16'hFFFF; cleared only by Reset.
- Undefined: the IdleCount port and its logic are absent.

## Structure
- Package tx_sched_pkg holds:
  - the state enum;
  - WORD_W=10 and CNT_W=4;
  - the K28_5_RDN constant and the RD+ derivation.
- Sub-module tx_word_fifo: the 2-entry FIFO with full/empty flags, push/pop and asynchronous reset.

## Test plan
- Reset, then Enable=1, ALIGN_WORDS=2, no data → Load at edge 1 with 10'h0FA; Load at edge 11 with 10'h305; edge 21 enters S_DATA and loads 10'h0FA with IdleInserted=1.
- Push 10'h2AA during the preamble → loaded at the first S_DATA boundary with IdleInserted=0, held for 10 cycles while bit_count runs 9→0.
- Drive TxValid continuously with distinct words → TxReady drops after 2 pushes; words appear in order, one per 10 cycles, with no comma between them.
- Deassert Enable at bit_count=5 → the word finishes. At the next boundary TxParallel_10=0 and bit_count=0 with no Load; the FIFO word is loaded after re-enable and preamble.
- Assert Reset with bit_count=4 and FIFO full → all outputs are 0 immediately, TxReady=0, the FIFO is empty after release, and the comma disparity restarts at RD−.
- With TX_SCHED_STATS_EN: 3 S_DATA idles → IdleCount=3; a preset near saturation stays at 16'hFFFF.
